buf_arbiter: RTL and testbench
==============================

# buf_arbiter

Two-port arbiter and burst sequencer for the 2048 x 16-bit page buffer in the NAND flash controller. It shares the buffer's single access port between the host-side interface and the flash-side engine. Each granted requester gets one burst of 1 to 2048 consecutive words, one word per cycle, with address wrap-around. It sits between the two requesters and the buffer unit, and it generates the buffer's enable, write, address and data signals.

## Interface
- DW, 16, buffer word width
- AW, 11, buffer address width (depth 2^AW = 2048)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- In the lines below, x is h (host) or f (flash); each port exists once per requester.
- x_req  in  1  burst request; held until x_gnt
- x_we  in  1  1 = write burst, 0 = read burst
- x_addr  in  AW  burst start address
- x_len  in  AW  burst length minus one (0 → 1 word, 2047 → 2048 words)
- x_wdata  in  DW  current write word
- x_gnt  out  1  burst in progress for this requester
- x_wack  out  1  write word consumed this cycle; requester advances x_wdata on the next cycle
- x_rvalid  out  1  x_rdata valid
- x_rdata  out  DW  read word
- x_done  out  1  one-cycle pulse at burst end
- buf_en  out  1  buffer access this cycle
- buf_we  out  1  buffer write strobe
- buf_addr  out  AW  buffer address
- buf_wdata  out  DW  buffer write data
- buf_rdata  in  DW  buffer read data, valid one cycle after a read access

## Operation
- FSM states:
  - IDLE: arbitrate. If any x_req is high, latch the winner's we, addr and len into the cmd/addr/remaining registers and go to XFER.
  - XFER: one access per cycle at the addr register. Each cycle, addr increments modulo 2^AW and remaining decrements. When remaining == 0 on an access, go to DONE.
  - DONE: assert x_done, return the last read word if the burst is a read, then go to IDLE.
- Arbitration: with BUF_ARB_RR_EN defined, round-robin on simultaneous requests (see Configuration); a single request always wins.
- During a burst:
  - x_gnt is high in XFER and DONE.
  - The other requester's req is ignored until IDLE.
  - Changes to the granted requester's x_we, x_addr and x_len after grant have no effect.
- Writes:
  - buf_en = buf_we = 1.
  - buf_wdata = winner's x_wdata (combinational pass-through).
  - x_wack = 1 on the same cycle.
- Reads:
  - buf_en = 1, buf_we = 0.
  - x_rvalid is registered: it is high on the cycle after each access, with x_rdata = buf_rdata.
- Non-granted requester: gnt, wack, rvalid and done stay 0; rdata is 0.
- Withdrawal: deasserting x_req before x_gnt withdraws the request with no side effects.

## Timing
- Reset values:
  - State IDLE; all outputs 0.
  - Round-robin pointer set so that flash wins the first tie.
- Reset asserted mid-burst: the burst is abandoned immediately. No done pulse is issued and nothing further is written.
- Grant latency: req sampled high in IDLE at cycle t → x_gnt high and first buffer access at t+1.
- Burst of N words:
  - Accesses on cycles t+1 .. t+N.
  - DONE at t+N+1.
  - IDLE at t+N+2.
  - Earliest next grant at t+N+3.
  - Occupancy is N+2 cycles per burst.
- Read data: word k (0-based) appears on x_rvalid/x_rdata at cycle t+2+k. The last word coincides with x_done.
- Address wrap: 0x7FF → 0x000 with no gap or stall.
- Maximum burst: x_len = 0x7FF produces 2048 accesses and returns the start address to its original value.

## Configuration
- BUF_ARB_RR_EN:
  - Defined: round-robin. On a tie, the requester not served most recently wins; the pointer updates on each grant.
  - Undefined: fixed priority. Flash always wins ties and the pointer logic is removed; the host can starve under continuous flash requests.

## Test plan
- Host write, x_addr = 0x010, x_len = 3, wdata 0xA000..0xA003:
  - buf_we on 4 consecutive cycles at addresses 0x010–0x013.
  - x_wack high for 4 cycles.
  - h_done pulses one cycle after the last access.
- Flash read of the same region (x_addr = 0x010, x_len = 3) → f_rvalid on 4 consecutive cycles returning 0xA000..0xA003, with f_done coinciding with the last rvalid.
- Host write, x_addr = 0x7FE, x_len = 3 → buf_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Both req high in the same IDLE cycle, repeated:
  - With BUF_ARB_RR_EN: grants alternate f, h, f, h.
  - Without it: f, f, f.
- Full-page burst, x_len = 0x7FF:
  - Write 2048 randomized words via host, then read back via flash.
  - All 2048 words match; occupancy is 2050 cycles.
- rst asserted during a write burst after 5 of 10 words:
  - Next cycle all outputs are 0; no x_done.
  - A subsequent read shows only the first 5 words updated.

Source files
------------

// File: rtl/buf_arbiter_if.sv
// buf_arbiter_if: bundle of both requester ports (host h_*, flash f_*) and the
// page-buffer access port shared by buf_arbiter.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_len stable and holds
// it until x_gnt rises. While x_gnt is high the burst runs one word per cycle.
// On writes, x_wack marks that x_wdata was consumed this cycle and the next
// word must be presented on the following cycle. On reads, x_rvalid qualifies
// x_rdata. x_done pulses once on the final burst cycle. Dropping x_req before
// x_gnt withdraws the request.
interface buf_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 11
);
    // host requester
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [AW-1:0] h_len;
    logic [DW-1:0] h_wdata;
    logic          h_gnt;
    logic          h_wack;
    logic          h_rvalid;
    logic [DW-1:0] h_rdata;
    logic          h_done;

    // flash requester
    logic          f_req;
    logic          f_we;
    logic [AW-1:0] f_addr;
    logic [AW-1:0] f_len;
    logic [DW-1:0] f_wdata;
    logic          f_gnt;
    logic          f_wack;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          f_done;

    // page buffer access port
    logic          buf_en;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;
    logic [DW-1:0] buf_rdata;

    // requesters plus the buffer unit
    modport master (
        output h_req, h_we, h_addr, h_len, h_wdata,
        input  h_gnt, h_wack, h_rvalid, h_rdata, h_done,
        output f_req, f_we, f_addr, f_len, f_wdata,
        input  f_gnt, f_wack, f_rvalid, f_rdata, f_done,
        input  buf_en, buf_we, buf_addr, buf_wdata,
        output buf_rdata
    );

    // the arbiter
    modport slave (
        input  h_req, h_we, h_addr, h_len, h_wdata,
        output h_gnt, h_wack, h_rvalid, h_rdata, h_done,
        input  f_req, f_we, f_addr, f_len, f_wdata,
        output f_gnt, f_wack, f_rvalid, f_rdata, f_done,
        output buf_en, buf_we, buf_addr, buf_wdata,
        input  buf_rdata
    );
endinterface

// File: rtl/buf_arbiter.sv
// buf_arbiter: shares the single access port of the 2048 x 16 page buffer
// between the host interface and the flash engine. A granted requester gets
// one burst of 1..2048 consecutive words (one per cycle, address wraps).
//
// Optional feature macro: BUF_ARB_RR_EN
//   defined   -> round-robin on simultaneous requests (flash wins first tie)
//   undefined -> fixed priority, flash always wins ties
//
// Burst timeline for a request sampled in IDLE at cycle t with N words:
// accesses t+1..t+N (XFER), done pulse t+N+1 (DONE), IDLE again at t+N+2.
// Reset is synchronous but also blanks every output combinationally, so a
// burst interrupted by reset performs no further buffer write.
module buf_arbiter #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    buf_arbiter_if.slave         io_bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_own_f;     // 1: flash owns the burst, 0: host
    logic          r_we;        // latched burst direction
    logic [AW-1:0] r_addr;      // address of the current access
    logic [AW-1:0] r_rem;       // accesses left after the current one
    logic          r_gnt_h;
    logic          r_gnt_f;
    logic          r_done;
    logic          r_rvalid;    // a read access happened last cycle

    logic          w_any_req;
    logic          w_pick_f;
    logic          w_access;
    logic          w_wr_access;

`ifdef BUF_ARB_RR_EN
    logic          r_last_f;    // 1: flash was granted most recently

    // Round-robin winner: a lone request wins, a tie goes to whoever was not served last
    always_comb begin
        w_pick_f = io_bus.f_req & (~io_bus.h_req | ~r_last_f);
    end

    // Remember the most recent winner; reset makes flash win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_f <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_f <= w_pick_f;
        end
    end
`else
    // Fixed priority: flash wins whenever it requests
    always_comb begin
        w_pick_f = io_bus.f_req;
    end
`endif

    assign w_any_req = io_bus.h_req | io_bus.f_req;

    // Burst FSM: arbitrate in IDLE, stream words in XFER, flag completion in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_own_f  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_rem    <= '0;
            r_gnt_h  <= 1'b0;
            r_gnt_f  <= 1'b0;
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= 1'b0;
                    r_rvalid <= 1'b0;
                    if (w_any_req) begin
                        r_state <= S_XFER;
                        r_own_f <= w_pick_f;
                        r_gnt_h <= ~w_pick_f;
                        r_gnt_f <= w_pick_f;
                        if (w_pick_f) begin
                            r_we   <= io_bus.f_we;
                            r_addr <= io_bus.f_addr;
                            r_rem  <= io_bus.f_len;
                        end else begin
                            r_we   <= io_bus.h_we;
                            r_addr <= io_bus.h_addr;
                            r_rem  <= io_bus.h_len;
                        end
                    end
                end
                S_XFER: begin
                    // read data from this access returns next cycle
                    r_rvalid <= ~r_we;
                    // natural AW-bit overflow gives the 0x7FF -> 0x000 wrap
                    r_addr   <= r_addr + 1'b1;
                    r_rem    <= r_rem - 1'b1;
                    if (r_rem == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_done   <= 1'b0;
                    r_rvalid <= 1'b0;
                    r_gnt_h  <= 1'b0;
                    r_gnt_f  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_gnt_h  <= 1'b0;
                    r_gnt_f  <= 1'b0;
                    r_done   <= 1'b0;
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign w_access    = (r_state == S_XFER) & ~rst;
    assign w_wr_access = w_access & r_we;

    // Buffer port: one access per XFER cycle, write data passed straight through from the owner
    always_comb begin
        io_bus.buf_en    = w_access;
        io_bus.buf_we    = w_wr_access;
        io_bus.buf_addr  = '0;
        io_bus.buf_wdata = '0;
        if (w_access) begin
            io_bus.buf_addr = r_addr;
        end
        if (w_wr_access) begin
            io_bus.buf_wdata = r_own_f ? io_bus.f_wdata : io_bus.h_wdata;
        end
    end

    // Requester status: only the owner sees gnt/wack/rvalid/done; rdata is zero unless valid
    always_comb begin
        io_bus.h_gnt    = r_gnt_h & ~rst;
        io_bus.f_gnt    = r_gnt_f & ~rst;
        io_bus.h_wack   = w_wr_access & ~r_own_f;
        io_bus.f_wack   = w_wr_access & r_own_f;
        io_bus.h_rvalid = r_rvalid & ~r_own_f & ~rst;
        io_bus.f_rvalid = r_rvalid & r_own_f & ~rst;
        io_bus.h_done   = r_done & ~r_own_f & ~rst;
        io_bus.f_done   = r_done & r_own_f & ~rst;
        io_bus.h_rdata  = '0;
        io_bus.f_rdata  = '0;
        if (io_bus.h_rvalid) begin
            io_bus.h_rdata = io_bus.buf_rdata;
        end
        if (io_bus.f_rvalid) begin
            io_bus.f_rdata = io_bus.buf_rdata;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_buf_arbiter.sv
// tb_buf_arbiter: bench for buf_arbiter. Contains a behavioural page buffer,
// a reference image of the buffer contents (ref_mem) updated from the burst
// rules, and an expected-read queue (exp_q).
module tb_buf_arbiter;
    localparam int DW    = 16;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    buf_arbiter_if #(.DW(DW), .AW(AW)) bif ();

    buf_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (bif),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // page buffer: data returned one cycle after a read access
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_rdata;
    always @(posedge clk) begin
        if (bif.buf_en) begin
            if (bif.buf_we) mem[bif.buf_addr] <= bif.buf_wdata;
            else            mem_rdata <= mem[bif.buf_addr];
        end
    end
    assign bif.buf_rdata = mem_rdata;

    // reference model and scoreboard
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            total = 0;
    int            bad   = 0;
    bit            last_f = 1'b0;   // most recently granted requester (1 = flash)

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // tie winner from the arbitration rule: 1 = flash
    function automatic bit win_model();
`ifdef BUF_ARB_RR_EN
        return !last_f;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit get_gnt(input bit who);
        return who ? bif.f_gnt : bif.h_gnt;
    endfunction
    function automatic bit get_wack(input bit who);
        return who ? bif.f_wack : bif.h_wack;
    endfunction
    function automatic bit get_rvalid(input bit who);
        return who ? bif.f_rvalid : bif.h_rvalid;
    endfunction
    function automatic bit get_done(input bit who);
        return who ? bif.f_done : bif.h_done;
    endfunction
    function automatic logic [DW-1:0] get_rdata(input bit who);
        return who ? bif.f_rdata : bif.h_rdata;
    endfunction

    // driver tasks
    task automatic set_ctrl(input bit who, input bit req, input bit we, input int addr, input int len);
        logic [AW-1:0] a;
        logic [AW-1:0] l;
        a = addr[AW-1:0];
        l = len[AW-1:0];
        if (who) begin
            bif.f_req = req; bif.f_we = we; bif.f_addr = a; bif.f_len = l;
        end else begin
            bif.h_req = req; bif.h_we = we; bif.h_addr = a; bif.h_len = l;
        end
    endtask

    task automatic set_wdata(input bit who, input logic [DW-1:0] wd);
        if (who) bif.f_wdata = wd;
        else     bif.h_wdata = wd;
    endtask

    // Full burst with per-cycle checks. Must start with the arbiter idle.
    // Cycle j = 1 is the grant cycle; accesses j = 1..n, done at n+1, idle at n+2.
    task automatic run_burst(input bit who, input bit we, input int addr, input int len,
                             input bit rnd, output int last_addr, output int occ);
        int            n;
        int            k;
        int            c;
        int            gcnt;
        int            a;
        bit            got;
        logic [DW-1:0] wq[$];
        logic [DW-1:0] w;
        logic [DW-1:0] e;
        n = len + 1; k = 0; gcnt = 0; last_addr = -1; occ = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom_range(0, 65535)) : DW'(16'hA000 + i);
            wq.push_back(w);
            if (!we) exp_q.push_back(ref_mem[(addr + i) % DEPTH]);
        end
        @(posedge clk); #1;
        set_ctrl(who, 1'b1, we, addr, len);
        set_wdata(who, wq[0]);
        got = 1'b0; c = 0;
        while (!got && c < 100) begin
            @(posedge clk); #2;
            if (get_gnt(who)) got = 1'b1;
            else c++;
        end
        if (!got) begin
            chk("grant_timeout", 0, 1);
            set_ctrl(who, 1'b0, 1'b0, 0, 0);
            exp_q.delete();
            return;
        end
        chk("grant_latency", c, 0);
        last_f = who;
        for (int j = 1; j <= n + 2; j++) begin
            if (j > 1) begin
                @(posedge clk); #1;
                set_wdata(who, (k < n) ? wq[k] : '0);
                #1;
            end
            a = (addr + j - 1) % DEPTH;
            if (get_gnt(who)) gcnt++;
            chk("other_gnt", int'(get_gnt(!who)), 0);
            if (j <= n) begin
                chk("gnt", int'(get_gnt(who)), 1);
                chk("buf_en", int'(bif.buf_en), 1);
                chk("buf_we", int'(bif.buf_we), int'(we));
                chk("buf_addr", int'(bif.buf_addr), a);
                chk("wack", int'(get_wack(who)), int'(we));
                chk("done_early", int'(get_done(who)), 0);
                if (we) chk("buf_wdata", int'(bif.buf_wdata), int'(wq[j-1]));
                if (j == n) last_addr = int'(bif.buf_addr);
            end else if (j == n + 1) begin
                chk("gnt_done", int'(get_gnt(who)), 1);
                chk("done_pulse", int'(get_done(who)), 1);
                chk("buf_en_done", int'(bif.buf_en), 0);
            end else begin
                chk("gnt_release", int'(get_gnt(who)), 0);
                chk("done_clear", int'(get_done(who)), 0);
            end
            chk("rvalid", int'(get_rvalid(who)), int'(!we && j >= 2 && j <= n + 1));
            if (get_rvalid(who)) begin
                if (exp_q.size() == 0) begin
                    chk("rdata_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", int'(get_rdata(who)), int'(e));
                end
            end
            if (get_wack(who)) k++;
            // drop req and scramble the command; the latched burst must not change
            if (j == 1) set_ctrl(who, 1'b0, 1'($urandom_range(0, 1)),
                                 int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
        end
        chk("rdata_count", exp_q.size(), 0);
        exp_q.delete();
        if (we) for (int i = 0; i < n; i++) ref_mem[(addr + i) % DEPTH] = wq[i];
        occ = gcnt + 1;
    endtask

    typedef struct {
        bit who;        // 1 = flash
        bit we;
        int addr;
        int len;
        int exp_last;   // address of the final access
        int exp_occ;    // cycles the arbiter is occupied
    } vec_t;

    vec_t vecs [5];

    initial begin
        int  la;
        int  oc;
        int  ra;
        int  wk;
        bit  exp_f;
        bit  hseen;
        bit  weseen;
        bit  dseen;
        bit  rwho;
        bit  rwe;
        int  rlen;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mem_rdata = '0;
        set_ctrl(1'b0, 1'b0, 1'b0, 0, 0);
        set_ctrl(1'b1, 1'b0, 1'b0, 0, 0);
        set_wdata(1'b0, '0);
        set_wdata(1'b1, '0);

        vecs[0] = '{who: 1'b0, we: 1'b1, addr: 'h010, len: 3, exp_last: 'h013, exp_occ: 6};
        vecs[1] = '{who: 1'b1, we: 1'b0, addr: 'h010, len: 3, exp_last: 'h013, exp_occ: 6};
        vecs[2] = '{who: 1'b0, we: 1'b1, addr: 'h7FE, len: 3, exp_last: 'h001, exp_occ: 6};
        vecs[3] = '{who: 1'b1, we: 1'b1, addr: 'h7FF, len: 0, exp_last: 'h7FF, exp_occ: 3};
        vecs[4] = '{who: 1'b0, we: 1'b0, addr: 'h7FF, len: 1, exp_last: 'h000, exp_occ: 4};

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", int'(bif.h_gnt | bif.f_gnt), 0);
        chk("rst_status", int'(bif.h_wack | bif.f_wack | bif.h_rvalid | bif.f_rvalid | bif.h_done | bif.f_done), 0);
        chk("rst_buf", int'(bif.buf_en | bif.buf_we), 0);
        chk("rst_buf_addr", int'(bif.buf_addr), 0);
        chk("rst_rdata", int'(bif.h_rdata | bif.f_rdata), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_f = 1'b0;

        // simultaneous requests right after reset
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            set_ctrl(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 2047)), 0);
            set_ctrl(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 2047)), 0);
            @(posedge clk); #2;
            exp_f = win_model();
            chk("tie_f_gnt", int'(bif.f_gnt), int'(exp_f));
            chk("tie_h_gnt", int'(bif.h_gnt), int'(!exp_f));
            last_f = exp_f;
            set_ctrl(1'b0, 1'b0, 1'b0, 0, 0);
            set_ctrl(1'b1, 1'b0, 1'b0, 0, 0);
            @(posedge clk);
        end

        // directed vectors
        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].len, 1'b0, la, oc);
            chk("vec_last_addr", la, vecs[i].exp_last);
            chk("vec_occ", oc, vecs[i].exp_occ);
        end

        // host request raised and withdrawn while flash owns the buffer
        @(posedge clk); #1;
        set_ctrl(1'b1, 1'b1, 1'b0, 'h200, 2);
        @(posedge clk); #2;
        chk("wd_f_gnt", int'(bif.f_gnt), 1);
        set_ctrl(1'b1, 1'b0, 1'b0, 0, 0);
        set_ctrl(1'b0, 1'b1, 1'b1, 'h300, 0);
        set_wdata(1'b0, 16'hDEAD);
        hseen = 1'b0; weseen = 1'b0;
        for (int j = 2; j <= 8; j++) begin
            @(posedge clk); #1;
            if (j == 2) set_ctrl(1'b0, 1'b0, 1'b0, 0, 0);
            #1;
            hseen  = hseen | bif.h_gnt;
            weseen = weseen | bif.buf_we;
        end
        chk("wd_h_gnt", int'(hseen), 0);
        chk("wd_buf_we", int'(weseen), 0);
        last_f = 1'b1;

        // randomized bursts
        for (int i = 0; i < 20; i++) begin
            rwho = 1'($urandom_range(0, 1));
            rwe  = 1'($urandom_range(0, 1));
            ra   = int'($urandom_range(0, 2047));
            rlen = int'($urandom_range(0, 40));
            run_burst(rwho, rwe, ra, rlen, 1'b1, la, oc);
            chk("rand_last_addr", la, (ra + rlen) % DEPTH);
            chk("rand_occ", oc, rlen + 3);
        end

        // full page write then read back
        ra = int'($urandom_range(0, 2047));
        run_burst(1'b0, 1'b1, ra, 2047, 1'b1, la, oc);
        chk("page_wr_last", la, (ra + 2047) % DEPTH);
        chk("page_wr_occ", oc, 2050);
        run_burst(1'b1, 1'b0, ra, 2047, 1'b0, la, oc);
        chk("page_rd_occ", oc, 2050);

        // reset after 5 of 10 write words
        @(posedge clk); #1;
        set_ctrl(1'b0, 1'b1, 1'b1, 'h100, 9);
        set_wdata(1'b0, 16'hB000);
        @(posedge clk); #2;
        chk("rb_gnt", int'(bif.h_gnt), 1);
        set_ctrl(1'b0, 1'b0, 1'b0, 0, 0);
        wk = 0; dseen = 1'b0;
        if (bif.h_wack) wk++;
        for (int j = 2; j <= 5; j++) begin
            @(posedge clk); #1;
            set_wdata(1'b0, DW'(16'hB000 + wk));
            #1;
            if (bif.h_wack) wk++;
        end
        @(posedge clk); #1;
        set_wdata(1'b0, DW'(16'hB000 + wk));
        rst = 1'b1;
        #1;
        dseen = dseen | bif.h_done;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rb_wack_count", wk, 5);
        chk("rb_status", int'(bif.h_gnt | bif.f_gnt | bif.h_wack | bif.f_wack | bif.h_rvalid | bif.f_rvalid), 0);
        chk("rb_buf", int'(bif.buf_en | bif.buf_we), 0);
        chk("rb_buf_addr", int'(bif.buf_addr), 0);
        chk("rb_buf_wdata", int'(bif.buf_wdata), 0);
        chk("rb_rdata", int'(bif.h_rdata | bif.f_rdata), 0);
        for (int j = 0; j < 4; j++) begin
            dseen = dseen | bif.h_done;
            @(posedge clk); #2;
        end
        chk("rb_no_done", int'(dseen), 0);
        for (int i = 0; i < 5; i++) ref_mem['h100 + i] = DW'(16'hB000 + i);
        last_f = 1'b0;
        run_burst(1'b1, 1'b0, 'h100, 9, 1'b0, la, oc);
        chk("rb_read_occ", oc, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
